// File: rtl/fft_tx_pkg.sv
// rtl/fft_tx_pkg.sv - shared types and helpers for the FFT frame transmit scheduler
package fft_tx_pkg;

    localparam int WORD_W = 16;
    localparam int MAX_CH = 8;
    localparam logic [WORD_W-1:0] HDR_WORD_DEFAULT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        ID,
        DATA,
        CSUM,
        DONE
    } state_e;

    function automatic logic [WORD_W-1:0] csum_add(input logic [WORD_W-1:0] acc,
                                                   input logic [WORD_W-1:0] word);
        return acc + word;
    endfunction

    // First requester strictly after ptr, wrapping within nch channels.
    function automatic logic [2:0] rr_pick(input logic [MAX_CH-1:0] req,
                                           input logic [2:0]        ptr,
                                           input int unsigned       nch);
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_CH; i++) begin
            idx = (32'(ptr) + i) % nch;
            if (!found && (i <= nch) && req[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/word_skid_fifo.sv
// rtl/word_skid_fifo.sv - two-entry word FIFO absorbing buffer read latency
import fft_tx_pkg::*;

module word_skid_fifo (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              pop_i,
    output logic [WORD_W-1:0] data_o,
    output logic [1:0]        count_o
);

    logic [WORD_W-1:0] mem_q [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fft_frame_tx_scheduler.sv
// rtl/fft_frame_tx_scheduler.sv - round-robin framer sharing one tx path among FFT buffers
import fft_tx_pkg::*;

module fft_frame_tx_scheduler #(
    parameter int                NCH       = 2,
    parameter int                FRAME_LEN = 64,
    parameter int                AW        = 6,
    parameter int                HDR_LEN   = 3,
    parameter logic [WORD_W-1:0] HDR_WORD  = HDR_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    req,
    output logic [NCH-1:0]    grant,
    output logic [NCH-1:0]    done,
    output logic              rd_en,
    output logic [AW-1:0]     rd_addr,
    input  logic [WORD_W-1:0] rd_data,
    output logic [WORD_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [NCH-1:0]    grant_q, grant_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        owner_q, owner_d;
    logic [15:0]       hdr_cnt_q, hdr_cnt_d;
    logic [AW:0]       rd_cnt_q, rd_cnt_d;
    logic [AW:0]       acc_cnt_q, acc_cnt_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic [WORD_W-1:0] csum_q, csum_d;
    logic              inflight_q;

    logic [MAX_CH-1:0] req_ext;
    logic [2:0]        pick;
    logic [2:0]        occ;
    logic              pop;
    logic [WORD_W-1:0] fifo_head;
    logic [1:0]        fifo_count;

    word_skid_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q),
        .data_i  (rd_data),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .count_o (fifo_count)
    );

    always_comb begin
        req_ext          = '0;
        req_ext[NCH-1:0] = req;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        hdr_cnt_d = hdr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        acc_cnt_d = acc_cnt_q;
        rd_addr_d = rd_addr_q;
        csum_d    = csum_q;
        pick      = rr_pick(req_ext, ptr_q, NCH);
        occ       = 3'd0;
        pop       = 1'b0;
        rd_en     = 1'b0;
        done      = '0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        tx_last   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    ptr_d     = pick;
                    owner_d   = pick;
                    grant_d   = NCH'(1) << pick;
                    hdr_cnt_d = '0;
                    rd_cnt_d  = '0;
                    acc_cnt_d = '0;
                    rd_addr_d = '0;
                    csum_d    = '0;
                    state_d   = HDR;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = HDR_WORD;
                if (tx_ready) begin
                    if (hdr_cnt_q == 16'(HDR_LEN - 1)) begin
                        state_d = ID;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 16'd1;
                    end
                end
            end
            ID: begin
                tx_valid = 1'b1;
                tx_data  = {13'b0, owner_q};
                if (tx_ready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_valid = (fifo_count != 2'd0);
                tx_data  = fifo_head;
                pop      = tx_valid && tx_ready;
                // Count the word leaving this cycle as free space so a full pipe streams 1 word/cycle.
                occ      = 3'(fifo_count) - 3'(pop) + 3'(inflight_q);
                if ((rd_cnt_q < (AW+1)'(FRAME_LEN)) && (occ < 3'd2)) begin
                    rd_en     = 1'b1;
                    rd_cnt_d  = rd_cnt_q + 1'b1;
                    rd_addr_d = (rd_cnt_q == (AW+1)'(FRAME_LEN - 1)) ? '0 : rd_addr_q + 1'b1;
                end
                if (pop) begin
                    csum_d    = csum_add(csum_q, fifo_head);
                    acc_cnt_d = acc_cnt_q + 1'b1;
                    if (acc_cnt_q == (AW+1)'(FRAME_LEN - 1)) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                tx_valid = 1'b1;
                tx_last  = 1'b1;
                tx_data  = csum_q;
                if (tx_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = grant_q;
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= 3'(NCH - 1);
            owner_q    <= '0;
            hdr_cnt_q  <= '0;
            rd_cnt_q   <= '0;
            acc_cnt_q  <= '0;
            rd_addr_q  <= '0;
            csum_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            hdr_cnt_q  <= hdr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            acc_cnt_q  <= acc_cnt_d;
            rd_addr_q  <= rd_addr_d;
            csum_q     <= csum_d;
            inflight_q <= rd_en;
        end
    end

    assign grant   = grant_q;
    assign rd_addr = rd_addr_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_fft_frame_tx_scheduler.sv
// tb/tb_fft_frame_tx_scheduler.sv - scoreboard bench for fft_frame_tx_scheduler
module tb_fft_frame_tx_scheduler;

    localparam int          NCH = 2;
    localparam int          FL  = 4;
    localparam int          AW  = 3;
    localparam int          HL  = 3;
    localparam logic [15:0] HW  = 16'hFFFF;

    logic           clk      = 1'b0;
    logic           rst_n    = 1'b1;
    logic [NCH-1:0] req      = '0;
    logic [NCH-1:0] grant;
    logic [NCH-1:0] done;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [15:0]    rd_data  = 16'hDEAD;
    logic [15:0]    tx_data;
    logic           tx_valid;
    logic           tx_ready = 1'b1;
    logic           tx_last;
    logic           busy;

    always #5 clk = ~clk;

    fft_frame_tx_scheduler #(
        .NCH       (NCH),
        .FRAME_LEN (FL),
        .AW        (AW),
        .HDR_LEN   (HL),
        .HDR_WORD  (HW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .grant    (grant),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_last  (tx_last),
        .busy     (busy)
    );

    typedef struct {
        logic [15:0]    data;
        logic           last;
        logic           is_data;
        logic [NCH-1:0] gnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] bufmem [NCH][FL];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_frame(input int ch);
        exp_t        e;
        logic [15:0] s;
        s         = '0;
        e.gnt     = NCH'(1) << ch;
        e.last    = 1'b0;
        e.is_data = 1'b0;
        for (int h = 0; h < HL; h++) begin
            e.data = HW;
            sb.push_back(e);
        end
        e.data = 16'(ch);
        sb.push_back(e);
        e.is_data = 1'b1;
        for (int i = 0; i < FL; i++) begin
            e.data = bufmem[ch][i];
            s      = s + bufmem[ch][i];
            sb.push_back(e);
        end
        e.is_data = 1'b0;
        e.last    = 1'b1;
        e.data    = s;
        sb.push_back(e);
    endtask

    // Buffer model: data for a read strobe appears one cycle later.
    logic          pend_en   = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    int            pend_ch   = 0;
    always @(negedge clk) begin
        rd_data   = pend_en ? bufmem[pend_ch][int'(pend_addr) % FL] : 16'hDEAD;
        pend_en   = rd_en && rst_n;
        pend_addr = rd_addr;
        pend_ch   = grant[1] ? 1 : 0;
    end

    logic       bp_mode  = 1'b0;
    logic [3:0] bp_pat   = 4'b1001;
    int         bp_phase = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (bp_mode) begin
            tx_ready = bp_pat[bp_phase];
            bp_phase = (bp_phase + 1) % 4;
        end else begin
            tx_ready = 1'b1;
            bp_phase = 0;
        end
    end

    logic [NCH-1:0] exp_done   = '0;
    logic           prev_stall = 1'b0;
    logic [15:0]    prev_data  = '0;
    logic           prev_last  = 1'b0;
    int             rd_total   = 0;
    int             dacc_total = 0;
    int             frame_dacc = 0;
    int             exp_addr   = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_done   = '0;
            prev_stall = 1'b0;
            rd_total   = 0;
            dacc_total = 0;
            frame_dacc = 0;
            exp_addr   = 0;
        end else begin
            check("done", 32'(done), 32'(exp_done));
            exp_done = '0;
            if (prev_stall) begin
                check("stall_valid", 32'(tx_valid), 32'd1);
                check("stall_data", 32'(tx_data), 32'(prev_data));
                check("stall_last", 32'(tx_last), 32'(prev_last));
            end
            if (rd_en) begin
                check("rd_addr", 32'(rd_addr), 32'(exp_addr));
                exp_addr = (exp_addr + 1) % FL;
                rd_total++;
            end
            if (tx_valid && tx_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(tx_data), 32'hFFFF_FFFF);
                end else begin
                    mon_e = sb.pop_front();
                    check("tx_data", 32'(tx_data), 32'(mon_e.data));
                    check("tx_last", 32'(tx_last), 32'(mon_e.last));
                    check("grant", 32'(grant), 32'(mon_e.gnt));
                    if (mon_e.is_data) begin
                        dacc_total++;
                        frame_dacc++;
                    end
                    if (mon_e.last) begin
                        exp_done   = mon_e.gnt;
                        frame_dacc = 0;
                    end
                end
            end
            check("occupancy", 32'((rd_total - dacc_total) > 2), 32'd0);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_last  = tx_last;
        end
    end

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        bp_mode = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (done == '0 && k < 300);
        if (done == '0) check(tag, 32'd0, 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_tx_last"}, 32'(tx_last), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic set_buf(input int ch, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
        bufmem[ch][0] = a;
        bufmem[ch][1] = b;
        bufmem[ch][2] = c;
        bufmem[ch][3] = d;
    endtask

    initial begin
        int k;
        set_buf(0, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        set_buf(1, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single channel frame
        push_frame(0);
        req = 2'b01;
        wait_done("single_timeout");
        req = '0;
        @(negedge clk);
        check("single_busy_idle", 32'(busy), 32'd0);
        check("single_grant_idle", 32'(grant), 32'd0);
        check("single_drain", 32'(sb.size()), 32'd0);

        // Both channels requesting continuously
        do_reset();
        set_buf(0, 16'h0010, 16'h0020, 16'h0030, 16'h0040);
        push_frame(0);
        push_frame(1);
        push_frame(0);
        push_frame(1);
        req = 2'b11;
        repeat (4) wait_done("both_timeout");
        req = '0;
        @(negedge clk);
        check("both_busy_idle", 32'(busy), 32'd0);
        check("both_drain", 32'(sb.size()), 32'd0);

        // Backpressure 1,0,0,1
        do_reset();
        set_buf(0, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        bp_mode = 1'b1;
        push_frame(0);
        req = 2'b01;
        wait_done("bp_timeout");
        req     = '0;
        bp_mode = 1'b0;
        @(negedge clk);
        check("bp_drain", 32'(sb.size()), 32'd0);

        // Checksum wrap-around
        do_reset();
        set_buf(0, 16'h8000, 16'h8000, 16'hFFFF, 16'h0001);
        push_frame(0);
        check("wrap_csum_model", 32'(sb[sb.size()-1].data), 32'h0000);
        req = 2'b01;
        wait_done("wrap_timeout");
        req = '0;
        @(negedge clk);
        check("wrap_drain", 32'(sb.size()), 32'd0);

        // Reset in the middle of the data phase
        do_reset();
        set_buf(0, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        push_frame(0);
        req = 2'b01;
        k   = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (frame_dacc < 2 && k < 300);
        check("midrst_reach_data", 32'(frame_dacc >= 2), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        sb.delete();
        req = 2'b10;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_frame(1);
        wait_done("midrst_timeout");
        req = '0;
        @(negedge clk);
        check("midrst_drain", 32'(sb.size()), 32'd0);

        // Back-to-back frames from one channel
        do_reset();
        push_frame(0);
        push_frame(0);
        req = 2'b01;
        wait_done("b2b_timeout1");
        req = '0;
        @(negedge clk);
        check("b2b_busy_gap", 32'(busy), 32'd0);
        req = 2'b01;
        @(negedge clk);
        check("b2b_busy_hdr", 32'(busy), 32'd1);
        check("b2b_hdr_valid", 32'(tx_valid), 32'd1);
        check("b2b_hdr_word", 32'(tx_data), 32'(HW));
        wait_done("b2b_timeout2");
        req = '0;
        @(negedge clk);
        check("b2b_drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/fft_frame_tx_scheduler.md
Name: fft_frame_tx_scheduler

Overview:
- Shares one framed transmit path among NCH FFT result buffers. Each buffer raises a request when a frame is ready.
- Arbitrates round-robin and reads the granted buffer's words.
- Emits one frame per grant: HDR_LEN sync words (HDR_WORD), one channel-ID word, FRAME_LEN data words, one checksum word.
- Sits between the FFT output buffers and the UART/word serializer. Replaces ad-hoc header insertion with a sequenced, backpressure-aware controller.

Parameters:
- NCH, 2, number of requesting channels (2..8)
- FRAME_LEN, 64, data words per frame (>=1)
- AW, 6, buffer address width; AW >= clog2(FRAME_LEN)
- HDR_LEN, 3, number of sync words (>=1)
- HDR_WORD, 16'hFFFF, sync word value

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- req  in  NCH  per-channel frame-ready; level, held until matching done
- grant  out  NCH  one-hot owner; held for the whole frame
- done  out  NCH  one-cycle pulse to the owner after the checksum word is accepted
- rd_en  out  1  read strobe to granted buffer
- rd_addr  out  AW  read address, 0..FRAME_LEN-1
- rd_data  in  16  granted buffer data; valid exactly 1 cycle after rd_en
- tx_data  out  16  word to serializer
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  serializer accepts when tx_valid && tx_ready
- tx_last  out  1  high with the checksum word
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release): grant=0, done=0, rd_en=0, rd_addr=0, tx_data=0, tx_valid=0, tx_last=0, busy=0. State=IDLE. RR pointer=NCH-1, so channel 0 wins first. Skid FIFO empty, checksum=0. Reset mid-frame drops the frame silently; no done is issued.
- States: IDLE -> HDR -> ID -> DATA -> CSUM -> DONE -> IDLE.
- IDLE: if req!=0, grant the first requester searching from ptr+1 upward, with wrap. Update ptr to the granted channel. Go to HDR the next cycle. The grant register updates at that same edge.
- HDR: present HDR_WORD with tx_valid=1. Hold until accepted. Count HDR_LEN accepts, then go to ID.
- ID: present {13'b0, channel index}. On accept, go to DATA.
- DATA: prefetch through a 2-entry skid FIFO. Issue rd_en when (FIFO occupancy + reads in flight) < 2 and reads issued < FRAME_LEN. rd_addr increments per rd_en starting at 0.
  - rd_data is pushed into the FIFO one cycle after rd_en.
  - The FIFO head drives tx_data. tx_valid = FIFO non-empty.
  - First data word appears at tx_valid no earlier than 2 cycles after ID accept.
  - Sustained throughput with tx_ready held at 1 is 1 word/cycle.
- Checksum: 16-bit sum mod 2^16 of the data words at accept time. Cleared on entry to HDR.
- After FRAME_LEN data accepts: CSUM presents the checksum with tx_last=1. On accept, go to DONE.
- DONE: a single cycle. done[owner]=1, grant cleared, busy=0 on the following cycle in IDLE. The requester must drop req within 1 cycle of done; a req still high in the next IDLE cycle counts as a new frame.
- tx_data/tx_valid/tx_last are stable while tx_valid && !tx_ready (AXI-style; no retraction).
- req changes during a frame are ignored. grant never changes mid-frame.
- A channel deasserting req mid-frame does not abort the frame.
- All-requesting case: grants rotate 0,1,..,NCH-1,0.
- rd_addr wraps to 0 at the end of each frame.

Decomposition:
- Shared package fft_tx_pkg: state enum (IDLE, HDR, ID, DATA, CSUM, DONE), HDR_WORD default, WORD_W=16, checksum function.
- Sub-module: word_skid_fifo, a 2-deep, 16-bit FIFO with count output, instantiated once.
- Round-robin pick is a function in the package; no separate module.

Test Plan:
- Single channel (NCH=2, HDR_LEN=3, FRAME_LEN=4, tx_ready=1): req=01, buffer 1,2,3,4 -> tx stream FFFF,FFFF,FFFF,0000,0001,0002,0003,0004,000A with tx_last only on 000A; done=01 pulse; rd_addr 0..3.
- Both requesting continuously -> frames emitted for channel 0, 1, 0, 1 with ID words 0000,0001,0000,0001; grant one-hot and stable within each frame.
- Backpressure: tx_ready toggles 1,0,0,1 repeating -> identical word sequence to scenario 1; no word dropped or duplicated; tx_data stable while stalled; rd_en never overflows the FIFO (occupancy+inflight <=2).
- Checksum wrap: data 8000,8000,FFFF,0001 -> checksum 0000.
- Reset mid-DATA (rst_n low after 2nd data word) -> all outputs 0 asynchronously; no done; after release a held req=10 is granted to channel 0's priority rule (ptr reset) -> channel 1 only requester, frame ID 0001.
- Back-to-back: req=01 reasserted the cycle after done -> next HDR word within 2 cycles of done; busy low for exactly 1 cycle between frames.
